// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR defaults, coefficient-loader state encoding and tap slicing helper
package fir_pkg;
  localparam int DEF_TAPS = 7;
  localparam int DEF_COEFF_BITS = 16;
  typedef enum logic [1:0] {LOAD, DRAIN, PEND} state_t;
  function automatic int tap_lsb(input int idx, input int bits);
    return idx * bits;
  endfunction
endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: shadow coefficient bank with atomic commit into the active bank
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int N  = DEF_TAPS,
  parameter int W  = DEF_COEFF_BITS,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_we,
  input  logic [IW-1:0]  i_idx,
  input  logic [W-1:0]   i_data,
  input  logic           i_commit,
  output logic [N*W-1:0] o_coeffs
);
  logic [N*W-1:0] r_shadow;
  logic [N*W-1:0] r_active;
  // shadow taps fill one beat at a time; the whole shadow copies to active in a single edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_we) r_shadow[tap_lsb(int'(i_idx), W) +: W] <= i_data;
      if (i_commit) r_active <= r_shadow;
    end
  end
  assign o_coeffs = r_active;
endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: valid/ready coefficient frame loader with frame checking and strobe-aligned commit
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int NUMBER_OF_TAPS = DEF_TAPS,
  parameter int COEFF_BITS     = DEF_COEFF_BITS,
  parameter int TAP_IDX_BITS   = $clog2(NUMBER_OF_TAPS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               coef_valid,
  input  logic [COEFF_BITS-1:0]              coef_data,
  input  logic                               coef_last,
  output logic                               coef_ready,
  input  logic                               clear,
  input  logic                               commit_strobe,
  output logic [COEFF_BITS*NUMBER_OF_TAPS-1:0] coeffs_out,
  output logic                               coeffs_loaded,
  output logic                               coeff_update,
  output logic                               frame_error
);
  localparam logic [TAP_IDX_BITS-1:0] LAST_IDX = TAP_IDX_BITS'(NUMBER_OF_TAPS - 1);
  state_t                  r_state, w_state_next;
  logic [TAP_IDX_BITS-1:0] r_idx, w_idx_next;
  logic                    r_err, w_err_next;
  logic                    r_loaded, r_update;
  logic                    w_acc, w_we, w_commit, w_at_last;
  // state, index and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LOAD;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_loaded <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_err    <= w_err_next;
      r_loaded <= r_loaded | w_commit;
      r_update <= w_commit;
    end
  end
  // frame checking, handshake and commit decision; clear overrides any beat or strobe
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_err_next   = r_err;
    w_we         = 1'b0;
    w_commit     = 1'b0;
    coef_ready   = r_state != PEND;
    w_acc        = coef_valid && coef_ready;
    w_at_last    = r_idx == LAST_IDX;
    if (clear) begin
      w_state_next = LOAD;
      w_idx_next   = '0;
      w_err_next   = 1'b0;
    end else begin
      case (r_state)
        LOAD: if (w_acc) begin
          w_we         = !(coef_last ^ w_at_last) && (coef_last || !w_at_last);
          w_state_next = w_at_last ? (coef_last ? PEND : DRAIN) : LOAD;
          w_err_next   = r_err | (coef_last ^ w_at_last);
          w_idx_next   = w_at_last ? r_idx : (coef_last ? '0 : r_idx + 1'b1);
        end
        DRAIN: if (w_acc && coef_last) begin
          w_state_next = LOAD;
          w_idx_next   = '0;
        end
        PEND: if (commit_strobe) begin
          w_commit     = 1'b1;
          w_state_next = LOAD;
          w_idx_next   = '0;
        end
        default: w_state_next = LOAD;
      endcase
    end
  end
  fir_coeff_bank #(
    .N (NUMBER_OF_TAPS),
    .W (COEFF_BITS),
    .IW(TAP_IDX_BITS)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_data  (coef_data),
    .i_commit(w_commit),
    .o_coeffs(coeffs_out)
  );
  assign coeffs_loaded = r_loaded;
  assign coeff_update  = r_update;
  assign frame_error   = r_err;
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed frames with a commit scoreboard checked on every coeff_update pulse
module tb_fir_coeff_loader;
  localparam int N = 7;
  localparam int W = 16;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           coef_valid = 1'b0;
  logic [W-1:0]   coef_data = '0;
  logic           coef_last = 1'b0;
  logic           coef_ready;
  logic           clear = 1'b0;
  logic           commit_strobe = 1'b0;
  logic [N*W-1:0] coeffs_out;
  logic           coeffs_loaded;
  logic           coeff_update;
  logic           frame_error;
  int             total = 0;
  int             bad = 0;
  logic [N*W-1:0] exp_q[$];
  logic [N*W-1:0] f_a, f_b, f_c, f_d, f_e, f_f;

  fir_coeff_loader dut (
    .clk          (clk),
    .rst          (rst),
    .coef_valid   (coef_valid),
    .coef_data    (coef_data),
    .coef_last    (coef_last),
    .coef_ready   (coef_ready),
    .clear        (clear),
    .commit_strobe(commit_strobe),
    .coeffs_out   (coeffs_out),
    .coeffs_loaded(coeffs_loaded),
    .coeff_update (coeff_update),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] frame(input logic [W-1:0] base);
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = base + W'(i);
    return f;
  endfunction

  // monitor: every coeff_update must match the oldest expected commit
  always @(negedge clk) begin
    if (!rst && coeff_update) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_commit: got %h expected no update", coeffs_out);
      end else begin
        chk("commit_data", coeffs_out, exp_q.pop_front());
        chk("commit_loaded", coeffs_loaded, 1);
      end
    end
  end

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l, input logic s = 1'b0, input logic c = 1'b0);
    coef_valid = 1'b1;
    coef_data = d;
    coef_last = l;
    commit_strobe = s;
    clear = c;
    @(negedge clk);
    chk("ready_at_beat", coef_ready, 1);
    pos();
    coef_valid = 1'b0;
    coef_last = 1'b0;
    commit_strobe = 1'b0;
    clear = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) beat(base + W'(i), (i + 1) == last_at);
  endtask

  task automatic strobe(input bit expect_commit, input logic [N*W-1:0] exp);
    if (expect_commit) exp_q.push_back(exp);
    commit_strobe = 1'b1;
    pos();
    commit_strobe = 1'b0;
    @(negedge clk);
    pos();
  endtask

  task automatic pend_ready_low(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("ready_low_pend", coef_ready, 0);
      pos();
    end
  endtask

  initial begin
    f_a = frame(16'h0001);
    f_b = frame(16'h00A0);
    f_c = frame(16'h0D00);
    f_d = frame(16'h0500);
    f_e = frame(16'h0F00);
    f_f = frame(16'h1100);
    repeat (3) pos();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_coeffs", coeffs_out, 0);
    chk("rst_loaded", coeffs_loaded, 0);
    chk("rst_update", coeff_update, 0);
    chk("rst_error", frame_error, 0);
    chk("rst_ready", coef_ready, 1);
    pos();

    send(16'h0001, 7, 7);
    pend_ready_low(5);
    strobe(1, f_a);
    chk("f1_tap0", coeffs_out[15:0], 16'h0001);
    chk("f1_tap6", coeffs_out[111:96], 16'h0007);
    chk("f1_loaded", coeffs_loaded, 1);
    chk("f1_ready_back", coef_ready, 1);

    send(16'h0BAD, 4, 4);
    chk("short_error", frame_error, 1);
    strobe(0, '0);
    strobe(0, '0);
    chk("short_held", coeffs_out, f_a);
    send(16'h00A0, 7, 7);
    strobe(1, f_b);
    chk("error_sticky", frame_error, 1);
    clear = 1'b1;
    pos();
    clear = 1'b0;
    chk("clear_error", frame_error, 0);
    chk("clear_held", coeffs_out, f_b);
    chk("clear_loaded", coeffs_loaded, 1);

    send(16'h0C00, 9, 9);
    chk("long_error", frame_error, 1);
    chk("long_ready", coef_ready, 1);
    strobe(0, '0);
    chk("long_held", coeffs_out, f_b);
    send(16'h0D00, 7, 7);
    strobe(1, f_c);

    send(16'h0500, 6, 0);
    beat(16'h0506, 1'b1, 1'b1);
    pend_ready_low(10);
    strobe(1, f_d);

    beat(16'h0E00, 1'b0);
    beat(16'h0E01, 1'b0);
    beat(16'h0E02, 1'b0, 1'b0, 1'b1);
    chk("clear_beat_error", frame_error, 0);
    send(16'h0F00, 7, 7);
    chk("clear_frame_noerr", frame_error, 0);
    strobe(1, f_e);

    send(16'h1100, 7, 7);
    coef_valid = 1'b1;
    coef_data = 16'hFFFF;
    coef_last = 1'b1;
    pend_ready_low(3);
    coef_valid = 1'b0;
    coef_last = 1'b0;
    strobe(1, f_f);
    chk("bp_noerr", frame_error, 0);

    send(16'h1200, 7, 7);
    rst = 1'b1;
    pos();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pend_coeffs", coeffs_out, 0);
    chk("rst_pend_loaded", coeffs_loaded, 0);
    chk("rst_pend_ready", coef_ready, 1);
    pos();
    strobe(0, '0);
    repeat (2) pos();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end
endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Write side of the FIR coefficient bus: accepts coefficients one tap per beat over a valid/ready stream into a shadow bank.
- When a complete, well-formed frame has been loaded, the bank is committed atomically on the filter's sample-boundary strobe.
- Drives the packed coefficient input of both stereo filter channels, so coefficients never change mid-convolution.

Parameters:
- NUMBER_OF_TAPS, 7, taps per frame; frame length is exact.
- COEFF_BITS, 16, width of one coefficient, two's complement.
- TAP_IDX_BITS, $clog2(NUMBER_OF_TAPS), width of the tap index counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- coef_valid  in  1  coefficient beat valid.
- coef_data  in  COEFF_BITS  coefficient value; tap 0 is sent first.
- coef_last  in  1  marks the final beat of a frame.
- coef_ready  out  1  loader can accept a beat.
- clear  in  1  abort the frame in progress; shadow write index returns to 0.
- commit_strobe  in  1  filter phase boundary (connect to phase_min).
- coeffs_out  out  COEFF_BITS*NUMBER_OF_TAPS  active bank; tap i sits at [i*COEFF_BITS +: COEFF_BITS].
- coeffs_loaded  out  1  sticky; high once any frame has been committed.
- coeff_update  out  1  one-cycle pulse in the cycle coeffs_out changes.
- frame_error  out  1  sticky; set on a malformed frame, cleared by clear or rst.

Behaviour:
- Beat accepted when coef_valid && coef_ready. Data is written to shadow[idx] on the rising clk edge; idx then increments.
- FSM states LOAD, DRAIN, PEND.
- Reset: state=LOAD, idx=0, coeffs_out=0, shadow=0, coeffs_loaded=0, coeff_update=0, frame_error=0. coef_ready=1 in the first cycle after reset.
- LOAD (coef_ready=1):
  - Accepted beat with last, idx==N-1: write shadow, go to PEND.
  - Accepted beat with last, idx<N-1 (short frame): set frame_error, set idx=0, stay in LOAD. The partial shadow content is never committed.
  - Accepted beat without last, idx==N-1 (long frame): set frame_error, go to DRAIN. That beat is not written.
- DRAIN (coef_ready=1): beats are accepted and discarded. An accepted beat with last sets idx=0 and goes to LOAD.
- PEND (coef_ready=0): waits for commit_strobe.
  - On strobe, coeffs_out <= shadow in one cycle; coeff_update=1 for that cycle; coeffs_loaded<=1; idx=0; go to LOAD.
  - Latency: coeffs_out is valid the cycle after the first commit_strobe sampled while in PEND.
  - A strobe in the same cycle as the last beat is accepted does NOT commit; the commit waits for the next strobe.
- clear (any state):
  - Takes priority over a simultaneous beat, which is dropped.
  - Next state LOAD, idx=0, frame_error=0.
  - coeffs_out and coeffs_loaded are unchanged; a pending commit is cancelled.
- coeffs_out changes only on commit; it is held through clear, errors and draining.
- rst mid-frame or in PEND: full return to reset values, including coeffs_out=0.
- Index wrap: idx never exceeds N-1. The long-frame check prevents overflow.
- No arithmetic is applied to coefficients; bit-exact pass-through.

Decomposition:
- Shared package (fir_pkg): default NUMBER_OF_TAPS and COEFF_BITS, FSM state encoding (LOAD/DRAIN/PEND), and a tap slice helper (index to bit offset). The same package is reused by the filter for unpacking.
- One natural sub-module: fir_coeff_bank, the shadow plus active register arrays with write-enable, index and commit inputs. The FSM and handshake remain in the top module.

Test Plan (N=7, COEFF_BITS=16):
- Frame 0x0001..0x0007 with last on beat 7, commit_strobe 5 cycles later:
  - coef_ready low from the cycle after beat 7 until the commit.
  - coeff_update pulses once.
  - coeffs_out[15:0]=0x0001, [111:96]=0x0007; coeffs_loaded=1.
- Short frame: 4 beats, last on beat 4, then strobes:
  - frame_error=1; coeffs_out unchanged.
  - A following good frame 0x00A0..0x00A6 commits correctly.
- Long frame: 9 beats, last on beat 9:
  - frame_error=1; beats 8–9 accepted in DRAIN.
  - No commit; the next frame loads starting at tap 0.
- Last beat and commit_strobe in the same cycle: no commit that cycle; commit occurs on the next strobe, 10 cycles later.
- clear asserted together with beat 3 of a frame:
  - Beat dropped; idx=0.
  - The next 7-beat frame commits with its own values, not mixed with the aborted frame.
- Backpressure with coef_valid held high in PEND: no beat is accepted.
- rst asserted in PEND: coeffs_out=0, coeffs_loaded=0, coef_ready=1 the next cycle.
